// File: rtl/aether_cmd_framer.sv
// Host command framer for the Aether instruction decoder: packs 3-byte frames into
// a one-cycle command and returns the decoder's 16-bit data as a 2-byte response.
module aether_cmd_framer #(
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [3:0]  NopOpcode     = 4'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic        engine_busy_i,
  output logic [3:0]  instruction_o,
  output logic [3:0]  param_1_o,
  output logic [15:0] param_2_o,
  output logic        cmd_issue_o,
  input  logic [15:0] data_i,
  output logic        frame_drop_o
);

  localparam int unsigned   CntW   = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {RX0, RX1, RX2, WAIT, ISSUE, TX_HI, TX_LO} state_e;

  state_e          state_q, state_d;
  logic [7:0]      byte0_q;
  logic [15:0]     param_2_q;
  logic [7:0]      resp_lo_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;
  logic            frame_drop_q;

  logic rx_fire, tx_fire, in_rx_timed, timeout;

  assign rx_ready_o  = (state_q == RX0) || (state_q == RX1) || (state_q == RX2);
  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign tx_fire     = tx_valid_q && tx_ready_i;
  assign in_rx_timed = (state_q == RX1) || (state_q == RX2);
  // An accepted byte always beats the timeout in the same cycle.
  assign timeout     = in_rx_timed && !rx_fire && (cnt_q == CntMax);

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX0:   if (rx_fire) state_d = RX1;
      RX1:   if (rx_fire) state_d = RX2; else if (timeout) state_d = RX0;
      RX2:   if (rx_fire) state_d = WAIT; else if (timeout) state_d = RX0;
      WAIT:  if (!engine_busy_i) state_d = ISSUE;
      ISSUE: state_d = TX_HI;
      TX_HI: if (tx_fire) state_d = TX_LO;
      TX_LO: if (tx_fire) state_d = RX0;
      default: state_d = RX0;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RX0;
      byte0_q      <= 8'h00;
      param_2_q    <= 16'h0000;
      resp_lo_q    <= 8'h00;
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_drop_q <= timeout;

      if (rx_fire) begin
        if (state_q == RX0) byte0_q         <= rx_data_i;
        if (state_q == RX1) param_2_q[15:8] <= rx_data_i;
        if (state_q == RX2) param_2_q[7:0]  <= rx_data_i;
      end

      if (in_rx_timed && !rx_fire && !timeout) cnt_q <= cnt_q + 1'b1;
      else                                     cnt_q <= '0;

      // High byte goes straight to the output register; low byte waits in resp_lo_q.
      if (state_q == ISSUE) begin
        resp_lo_q  <= data_i[7:0];
        tx_data_q  <= data_i[15:8];
        tx_valid_q <= 1'b1;
      end else if (tx_fire) begin
        if (state_q == TX_HI) tx_data_q  <= resp_lo_q;
        else                  tx_valid_q <= 1'b0;
      end
    end
  end

  // The decoder is combinational, so anything but NOP outside ISSUE would execute.
  assign cmd_issue_o   = (state_q == ISSUE);
  assign instruction_o = cmd_issue_o ? byte0_q[7:4] : NopOpcode;
  assign param_1_o     = cmd_issue_o ? byte0_q[3:0] : 4'h0;
  assign param_2_o     = cmd_issue_o ? param_2_q    : 16'h0000;
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign frame_drop_o  = frame_drop_q;

endmodule

// File: tb/tb_aether_cmd_framer.sv
// Scoreboard bench for aether_cmd_framer: stimulus pushes expected commands and
// response bytes; a negedge monitor pops and compares them as the DUT emits them.
module tb_aether_cmd_framer;

  localparam logic [3:0] Nop = 4'h0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        engine_busy_i = 1'b0;
  logic [3:0]  instruction_o;
  logic [3:0]  param_1_o;
  logic [15:0] param_2_o;
  logic        cmd_issue_o;
  logic [15:0] data_i;
  logic        frame_drop_o;

  logic [15:0] cur_resp = 16'h0000;
  // Decoder model: meaningful data only in the issue cycle, junk otherwise.
  assign data_i = cmd_issue_o ? cur_resp : 16'hDEAD;

  always #5 clk_i = ~clk_i;

  aether_cmd_framer #(.TimeoutCycles(16), .NopOpcode(Nop)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .engine_busy_i(engine_busy_i),
    .instruction_o(instruction_o), .param_1_o(param_1_o), .param_2_o(param_2_o),
    .cmd_issue_o(cmd_issue_o), .data_i(data_i), .frame_drop_o(frame_drop_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int drop_cnt = 0;

  logic [23:0] cmd_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard.
  initial begin
    logic       stall = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [23:0] e_cmd;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
        check("tx_hold_data", 32'(tx_data_o), 32'(stall_data));
      end
      if (cmd_issue_o) begin
        if (cmd_q.size() == 0) check("unexpected_cmd", {8'h0, instruction_o, param_1_o, param_2_o}, 32'hFFFFFFFF);
        else begin
          e_cmd = cmd_q.pop_front();
          check("cmd_fields", {8'h0, instruction_o, param_1_o, param_2_o}, {8'h0, e_cmd});
        end
      end else begin
        check("idle_nop", {8'h0, instruction_o, param_1_o, param_2_o}, {8'h0, Nop, 20'h0});
      end
      if (tx_valid_o && tx_ready_i) begin
        if (tx_q.size() == 0) check("unexpected_tx", 32'(tx_data_o), 32'hFFFFFFFF);
        else check("tx_byte", 32'(tx_data_o), 32'(tx_q.pop_front()));
      end
      stall      = tx_valid_o && !tx_ready_i;
      stall_data = tx_data_o;
      if (frame_drop_o) drop_cnt++;
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("rx_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [15:0] resp, input bit with_tx);
    cmd_q.push_back({b0, b1, b2});
    if (with_tx) begin
      tx_q.push_back(resp[15:8]);
      tx_q.push_back(resp[7:0]);
    end
    cur_resp = resp;
  endtask

  task automatic drain;
    int n = 0;
    while ((cmd_q.size() != 0 || tx_q.size() != 0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", 32'(n < 300), 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_tx_valid;
    int n = 0;
    while (!tx_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("tx_valid_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    int d0;
    int pulses;

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_cmd_issue", 32'(cmd_issue_o), 32'd0);
    check("rst_drop", 32'(frame_drop_o), 32'd0);
    check("rst_instr", {8'h0, instruction_o, param_1_o, param_2_o}, {8'h0, Nop, 20'h0});
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    check("rx_ready_after_rst", 32'(rx_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Read version with minimum-latency checks.
    expect_frame(8'h21, 8'h00, 8'h00, 16'h6C00, 1'b1);
    send_byte(8'h21);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk_i);
    check("lat_wait_issue", 32'(cmd_issue_o), 32'd0);
    check("lat_wait_rx_ready", 32'(rx_ready_o), 32'd0);
    @(negedge clk_i);
    check("lat_issue", 32'(cmd_issue_o), 32'd1);
    @(negedge clk_i);
    check("lat_tx_valid", 32'(tx_valid_o), 32'd1);
    check("lat_tx_hi", 32'(tx_data_o), 32'h6C);
    drain();
    @(negedge clk_i);
    check("read_rx_ready_back", 32'(rx_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Write with transmitter back-pressure.
    tx_ready_i = 1'b0;
    expect_frame(8'h35, 8'hAB, 8'hCD, 16'h1234, 1'b1);
    send_byte(8'h35);
    send_byte(8'hAB);
    send_byte(8'hCD);
    wait_tx_valid();
    for (int i = 0; i < 5; i++) begin
      check("wr_stall_rx_ready", 32'(rx_ready_o), 32'd0);
      check("wr_stall_data", 32'(tx_data_o), 32'h12);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    check("wr_hs1_rx_ready", 32'(rx_ready_o), 32'd0);
    @(negedge clk_i);
    check("wr_lo_rx_ready", 32'(rx_ready_o), 32'd0);
    check("wr_lo_data", 32'(tx_data_o), 32'h34);
    @(negedge clk_i);
    check("wr_done_rx_ready", 32'(rx_ready_o), 32'd1);
    drain();

    // Timeout: 16 idle cycles after byte0 discard the frame.
    d0 = drop_cnt;
    send_byte(8'h21);
    for (int i = 0; i < 15; i++) @(negedge clk_i);
    check("to_no_early_drop", drop_cnt - d0, 0);
    for (int i = 0; i < 20; i++) @(negedge clk_i);
    check("to_single_drop", drop_cnt - d0, 1);
    check("to_rx_ready", 32'(rx_ready_o), 32'd1);
    @(posedge clk_i); #1;
    expect_frame(8'h42, 8'h00, 8'h07, 16'hBEEF, 1'b1);
    send_byte(8'h42);
    send_byte(8'h00);
    send_byte(8'h07);
    drain();

    // Boundary: byte1 lands in the cycle the counter equals TimeoutCycles-1.
    d0 = drop_cnt;
    expect_frame(8'h5A, 8'h0F, 8'hF0, 16'hC3A5, 1'b1);
    send_byte(8'h5A);
    repeat (15) @(posedge clk_i);
    #1;
    send_byte(8'h0F);
    send_byte(8'hF0);
    drain();
    check("boundary_no_drop", drop_cnt - d0, 0);

    // Busy stall: 10 busy cycles in WAIT, issue the cycle after busy falls.
    engine_busy_i = 1'b1;
    expect_frame(8'h13, 8'h22, 8'h44, 16'h0F0F, 1'b1);
    send_byte(8'h13);
    send_byte(8'h22);
    send_byte(8'h44);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("busy_no_issue", 32'(cmd_issue_o), 32'd0);
      check("busy_nop", 32'(instruction_o), 32'(Nop));
      @(posedge clk_i); #1;
    end
    engine_busy_i = 1'b0;
    @(negedge clk_i);
    check("busy_fall_cycle", 32'(cmd_issue_o), 32'd0);
    @(negedge clk_i);
    check("busy_issue_next", 32'(cmd_issue_o), 32'd1);
    drain();

    // Reset during TX_HI: response discarded.
    tx_ready_i = 1'b0;
    expect_frame(8'h21, 8'h00, 8'h00, 16'hAAAA, 1'b0);
    send_byte(8'h21);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_tx_valid();
    check("pre_rst_cmd_consumed", cmd_q.size(), 0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    tx_ready_i = 1'b1;
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_rx_ready", 32'(rx_ready_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (tx_valid_o || cmd_issue_o) pulses++;
    end
    check("post_rst_silent", pulses, 0);
    @(posedge clk_i); #1;

    // Normal operation resumes after reset.
    expect_frame(8'h7E, 8'h55, 8'h66, 16'h8001, 1'b1);
    send_byte(8'h7E);
    send_byte(8'h55);
    send_byte(8'h66);
    drain();
    check("final_cmd_q_empty", cmd_q.size(), 0);
    check("final_tx_q_empty", tx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/aether_cmd_framer.md
Name: aether_cmd_framer

Overview:
- Sits directly upstream of the Aether instruction decoder.
- Assembles 3-byte host command frames from a byte stream (UART/SPI receiver side) into the decoder's instruction/param_1/param_2 fields, and presents each command for exactly one clock.
- Captures the decoder's 16-bit data output in that cycle and returns it to the host as a 2-byte response, with an inter-byte timeout that discards partial frames.

Parameters:
- TimeoutCycles, 1000000: idle cycles allowed between bytes of one frame before the partial frame is discarded; legal range 2 to 2^24-1.
- NopOpcode, 4'h0: opcode driven on instruction_o whenever no command is being issued.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  rx_data_i valid
- rx_ready_o  output  1  framer accepts byte; a transfer occurs when valid and ready are both high
- tx_data_o  output  8  response byte
- tx_valid_o  output  1  tx_data_o valid
- tx_ready_i  input  1  transmitter accepts byte
- engine_busy_i  input  1  downstream engine busy; stalls issue
- instruction_o  output  4  to decoder instruction input
- param_1_o  output  4  to decoder parameter 1 input
- param_2_o  output  16  to decoder parameter 2 input
- cmd_issue_o  output  1  one-cycle strobe, high in the issue cycle
- data_i  input  16  decoder data output, sampled in the issue cycle
- frame_drop_o  output  1  one-cycle strobe on timeout discard

Behaviour:
- Reset (asynchronous, active-low) values:
  - State RX0.
  - instruction_o = NopOpcode; param_1_o = 0; param_2_o = 0.
  - cmd_issue_o = 0, tx_valid_o = 0, tx_data_o = 0, frame_drop_o = 0.
  - rx_ready_o = 1 from the first cycle after reset release.
  - Timeout counter = 0; response register = 0.
- Frame format:
  - byte0 = {opcode[7:4], param_1[3:0]}
  - byte1 = param_2[15:8]
  - byte2 = param_2[7:0]
- States:
  - RX0: rx_ready_o = 1. On a transfer, latch byte0 and go to RX1.
  - RX1: rx_ready_o = 1. On a transfer, latch param_2 high byte and go to RX2.
  - RX2: rx_ready_o = 1. On a transfer, latch param_2 low byte and go to WAIT.
  - WAIT: rx_ready_o = 0. Stay while engine_busy_i = 1; otherwise go to ISSUE next cycle.
  - ISSUE: exactly one cycle.
    - instruction_o, param_1_o and param_2_o carry the latched frame; cmd_issue_o = 1.
    - data_i is registered into the response register at the end of this cycle.
    - Next state is TX_HI.
  - TX_HI: tx_valid_o = 1, tx_data_o = resp[15:8]. On handshake go to TX_LO.
  - TX_LO: tx_valid_o = 1, tx_data_o = resp[7:0]. On handshake go to RX0.
- Outside ISSUE:
  - instruction_o = NopOpcode, param_1_o = 0, param_2_o = 0.
  - The decoder is purely combinational, so any non-NOP value would act as a command.
- Minimum latency: byte2 accepted in cycle N, WAIT in N+1, ISSUE in N+2, tx_valid_o high in N+3.
- tx_valid_o and tx_data_o are registered outputs. tx_data_o is held stable while tx_valid_o = 1 and tx_ready_i = 0.
- rx_ready_o = 0 in WAIT, ISSUE, TX_HI and TX_LO. The framer processes one frame at a time and never overlaps RX with TX.
- Timeout:
  - The counter is active in RX1 and RX2 only. It clears on every accepted byte and increments every cycle without a transfer.
  - When the counter reaches TimeoutCycles-1, the next state is RX0, frame_drop_o pulses for one cycle, and the counter clears.
  - A byte arriving in that same cycle is accepted and the timeout does not fire: the transfer wins.
- engine_busy_i is sampled only in WAIT. It has no effect in other states and never aborts TX.
- Every issued command produces exactly 2 response bytes, including NOP and writes; for those, data_i is whatever the decoder presents (status register).
- Reset asserted mid-frame or mid-response: immediate return to reset values. No pending strobe or byte is emitted after release.
- Counter width is $clog2(TimeoutCycles); it never wraps.

Test Plan:
- Read version: bytes 0x21,0x00,0x00 with data_i = 0x6C00 in the issue cycle -> one cmd_issue_o pulse carrying instruction_o = 2, param_1_o = 1, param_2_o = 0x0000; tx bytes 0x6C then 0x00.
- Write: bytes 0x35,0xAB,0xCD with tx_ready_i held low 5 cycles -> ISSUE shows 3/5/0xABCD; tx_data_o = 0xxx held stable until ready; rx_ready_o low until the second tx handshake.
- Timeout: TimeoutCycles = 16; send 0x21, then idle 16 cycles -> frame_drop_o single pulse, no cmd_issue_o; a following 3-byte frame is issued normally.
- Boundary: byte1 arrives in exactly the cycle the counter equals TimeoutCycles-1 -> no drop, frame completes.
- Busy stall: engine_busy_i = 1 for 10 cycles after byte2 -> instruction_o stays NopOpcode throughout; ISSUE occurs the cycle after busy falls.
- Reset: assert rst_ni during TX_HI -> tx_valid_o = 0 immediately; no response bytes after release; rx_ready_o = 1 the cycle after release.
